bemf_sequencer: RTL and testbench
=================================

Name: bemf_sequencer

Overview:
- Upstream sequencer and accumulator store for the back-EMF update pipeline, which has a fixed 4-cycle latency.
- On each measurement trigger it sweeps motors 0..3. For each motor it:
  - waits a settle time;
  - converts the high-side and low-side ADC channels;
  - issues one update beat carrying both samples, the motor's current accumulator and its calibration value.
- It owns the four 20-bit accumulators, accepts the pipeline's write-back and exposes the accumulators to the register file.

Parameters:
- SETTLE_CYCLES, 16, idle cycles between motor selection and the first ADC request (1..255).
- ADC_TIMEOUT, 255, maximum cycles to wait for adc_ack before the motor is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- meas_trigger  in  1  single-cycle pulse; starts a sweep
- adc_req  out  1  conversion request
- adc_chan  out  3  {mot[1:0], side}; side 1 = high, 0 = low
- adc_ack  in  1  single-cycle; adc_data valid this cycle
- adc_data  in  10  conversion result
- bemf_calib_flat  in  80  motor m calibration at [20m+19:20m]
- bemf_adc_h  out  10  high-side sample to the update pipeline
- bemf_adc_l  out  10  low-side sample to the update pipeline
- mot_sel  out  2  motor index of the issued beat
- upd_valid  out  1  beat valid
- bemf_acc  out  20  current accumulator of mot_sel
- bemf_calib  out  20  calibration of mot_sel
- wb_valid  in  1  write-back strobe from the pipeline
- wb_mot_sel  in  2  write-back motor index
- wb_bemf  in  20  new accumulator value
- bemf_clear  in  4  per-motor accumulator clear
- bemf_flat  out  80  accumulators, packed the same way as bemf_calib_flat
- busy  out  1  sweep in progress
- sweep_done  out  1  single-cycle pulse at the end of a sweep
- err_timeout  out  4  sticky per-motor ADC-timeout flags
- err_overrun  out  1  sticky flag: trigger arrived while busy

Behaviour:
- Reset: clk and rst as stated; reset is synchronous and active-high.
  - FSM goes to IDLE.
  - All outputs, accumulators and sticky flags go to 0.
  - Asserting rst mid-sweep abandons the sweep with no issue and no sweep_done.
- FSM states: IDLE, SETTLE, REQ_H, REQ_L, ISSUE, DRAIN.
- IDLE:
  - meas_trigger moves to SETTLE with mot = 0.
  - Settle counter loads SETTLE_CYCLES-1.
- SETTLE:
  - Counter decrements each cycle; at 0 go to REQ_H.
- REQ_H:
  - adc_req = 1, adc_chan = {mot, 1}, held stable until the adc_ack cycle.
  - On ack: latch adc_data into h_reg, drop adc_req the next cycle, go to REQ_L. No back-to-back request in the same cycle.
- REQ_L:
  - Same handshake with adc_chan = {mot, 0}; latch into l_reg, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - upd_valid = 1, bemf_adc_h = h_reg, bemf_adc_l = l_reg, mot_sel = mot.
  - bemf_acc = acc[mot] and bemf_calib = calib[mot], registered at this cycle.
  - Outstanding counter increments.
  - If mot = 3 go to DRAIN; otherwise mot+1 and go to SETTLE.
- DRAIN:
  - Wait until outstanding = 0, then pulse sweep_done and go to IDLE.
- Timeout:
  - Cycle counter runs in REQ_H and REQ_L and resets on each new request.
  - When it reaches ADC_TIMEOUT: drop adc_req, set err_timeout[mot], skip ISSUE and advance as ISSUE would (next motor or DRAIN).
  - A late adc_ack after the timeout is ignored.
- Write-back:
  - wb_valid writes wb_bemf into acc[wb_mot_sel] and decrements outstanding.
  - If issue and write-back fall in the same cycle, outstanding is unchanged.
  - Each motor is issued at most once per sweep, so there is no read-after-write hazard.
  - bemf_clear[m] in the same cycle as a write-back to m: clear wins and acc[m] = 0.
- Outputs:
  - bemf_flat reflects the accumulators one cycle after each write.
  - busy = (state != IDLE).
- Overrun:
  - meas_trigger while busy is ignored and sets err_overrun.
  - A trigger in the same cycle as sweep_done is also an overrun.
- Arithmetic:
  - Accumulators are plain 20-bit two's-complement storage; wrap is the pipeline's concern.
  - outstanding is 3 bits and saturates at neither end. An underflow from a spurious wb_valid is a verification error.
- Sticky flags clear only on reset.

Decomposition:
- Shared package bemf_pkg holds:
  - N_MOT = 4, ADC_W = 10, BEMF_W = 20, UPD_LATENCY = 4;
  - the state enum;
  - the adc_chan side encoding.
- One natural sub-module, bemf_acc_bank: 4×20 register bank with write port, per-motor clear (priority over write), combinational read by mot_sel and flat export.

Test Plan:
- Sweep, ack 3 cycles after every req, data h=600/l=100 for all motors, calib 0, update stub adds 500 with latency 4 -> four upd_valid beats, mot_sel 0,1,2,3, each with bemf_adc_h=600, bemf_adc_l=100; acc[m]=500 after write-back; a single sweep_done after the 4th write-back; busy low the cycle after.
- SETTLE_CYCLES=16 -> first adc_req exactly 17 cycles after the trigger cycle; adc_chan sequence 1,0,3,2,5,4,7,6.
- Motor 2 high-side never acked -> adc_req drops after 255 cycles, err_timeout=4'b0100, only 3 upd_valid beats (mot 0,1,3), sweep_done still pulses.
- Trigger pulsed mid-sweep at motor 1 -> sweep unaffected, err_overrun=1, no second sweep starts.
- bemf_clear[1] in the same cycle as wb_valid with wb_mot_sel=1, wb_bemf=0x00123 -> acc[1]=0; other accumulators unchanged.
- rst asserted during motor 2 REQ_L -> next cycle adc_req=0, upd_valid=0, busy=0, all accumulators 0, no sweep_done; a new trigger restarts from motor 0.

Source files
------------

// File: rtl/bemf_pkg.sv
// Shared widths, FSM state encoding and ADC channel encoding for the back-EMF sequencer.
package bemf_pkg;

  localparam int unsigned N_MOT       = 4;
  localparam int unsigned MOT_W       = 2;
  localparam int unsigned ADC_W       = 10;
  localparam int unsigned BEMF_W      = 20;
  localparam int unsigned UPD_LATENCY = 4;

  localparam logic SIDE_HIGH = 1'b1;
  localparam logic SIDE_LOW  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ_H,
    ST_REQ_L,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  function automatic logic [MOT_W:0] adc_chan_enc(input logic [MOT_W-1:0] mot, input logic side);
    return {mot, side};
  endfunction

endpackage

// File: rtl/bemf_acc_bank.sv
// Four 20-bit accumulators: one write port, per-motor clear (wins over write), combinational read, flat export.
module bemf_acc_bank
  import bemf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [MOT_W-1:0]        i_wr_sel,
  input  logic [BEMF_W-1:0]       i_wr_data,
  input  logic [N_MOT-1:0]        i_clr,
  input  logic [MOT_W-1:0]        i_rd_sel,
  output logic [BEMF_W-1:0]       o_rd_data,
  output logic [N_MOT*BEMF_W-1:0] o_flat
);

  logic [BEMF_W-1:0] r_acc [N_MOT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned m = 0; m < N_MOT; m++) r_acc[m] <= '0;
    end else begin
      for (int unsigned m = 0; m < N_MOT; m++) begin
        if (i_clr[m])
          r_acc[m] <= '0;
        else if (i_wr_en && i_wr_sel == MOT_W'(m))
          r_acc[m] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_acc[i_rd_sel];

  always_comb begin
    o_flat = '0;
    for (int unsigned m = 0; m < N_MOT; m++) o_flat[m*BEMF_W +: BEMF_W] = r_acc[m];
  end

endmodule

// File: rtl/bemf_sequencer.sv
// Sweeps motors 0..3 per trigger: settle, convert high then low side, issue one update beat per motor.
module bemf_sequencer
  import bemf_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ADC_TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    meas_trigger,
  output logic                    adc_req,
  output logic [MOT_W:0]          adc_chan,
  input  logic                    adc_ack,
  input  logic [ADC_W-1:0]        adc_data,
  input  logic [N_MOT*BEMF_W-1:0] bemf_calib_flat,
  output logic [ADC_W-1:0]        bemf_adc_h,
  output logic [ADC_W-1:0]        bemf_adc_l,
  output logic [MOT_W-1:0]        mot_sel,
  output logic                    upd_valid,
  output logic [BEMF_W-1:0]       bemf_acc,
  output logic [BEMF_W-1:0]       bemf_calib,
  input  logic                    wb_valid,
  input  logic [MOT_W-1:0]        wb_mot_sel,
  input  logic [BEMF_W-1:0]       wb_bemf,
  input  logic [N_MOT-1:0]        bemf_clear,
  output logic [N_MOT*BEMF_W-1:0] bemf_flat,
  output logic                    busy,
  output logic                    sweep_done,
  output logic [N_MOT-1:0]        err_timeout,
  output logic                    err_overrun
);

  localparam int unsigned TMR_W = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ADC_TIMEOUT - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [MOT_W-1:0] LAST_MOT = MOT_W'(N_MOT - 1);

  state_t             r_state;
  logic [MOT_W-1:0]   r_mot;
  logic [7:0]         r_settle;
  logic [TMR_W-1:0]   r_tmr;
  logic [ADC_W-1:0]   r_h;
  logic [2:0]         r_out;
  logic               r_adc_req;
  logic [MOT_W:0]     r_adc_chan;
  logic [ADC_W-1:0]   r_bemf_adc_h;
  logic [ADC_W-1:0]   r_bemf_adc_l;
  logic [MOT_W-1:0]   r_mot_sel;
  logic               r_upd_valid;
  logic [BEMF_W-1:0]  r_bemf_acc;
  logic [BEMF_W-1:0]  r_bemf_calib;
  logic               r_sweep_done;
  logic [N_MOT-1:0]   r_err_timeout;
  logic               r_err_overrun;

  logic [BEMF_W-1:0]  w_acc_rd;
  logic [BEMF_W-1:0]  w_calib;
  logic               w_issue;

  bemf_acc_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wb_valid),
    .i_wr_sel  (wb_mot_sel),
    .i_wr_data (wb_bemf),
    .i_clr     (bemf_clear),
    .i_rd_sel  (r_mot),
    .o_rd_data (w_acc_rd),
    .o_flat    (bemf_flat)
  );

  assign w_calib = bemf_calib_flat[r_mot*BEMF_W +: BEMF_W];
  assign w_issue = (r_state == ST_ISSUE);

  // Beat outputs are loaded on the edge entering ISSUE so they are valid during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mot         <= '0;
      r_settle      <= '0;
      r_tmr         <= '0;
      r_h           <= '0;
      r_adc_req     <= 1'b0;
      r_adc_chan    <= '0;
      r_bemf_adc_h  <= '0;
      r_bemf_adc_l  <= '0;
      r_mot_sel     <= '0;
      r_upd_valid   <= 1'b0;
      r_bemf_acc    <= '0;
      r_bemf_calib  <= '0;
      r_sweep_done  <= 1'b0;
      r_err_timeout <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      r_upd_valid  <= 1'b0;
      if (meas_trigger && (r_state != ST_IDLE || r_sweep_done)) r_err_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (meas_trigger && !r_sweep_done) begin
            r_mot    <= '0;
            r_settle <= SETTLE_LOAD;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == '0) begin
            r_adc_req  <= 1'b1;
            r_adc_chan <= adc_chan_enc(r_mot, SIDE_HIGH);
            r_tmr      <= '0;
            r_state    <= ST_REQ_H;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        ST_REQ_H, ST_REQ_L: begin
          // REQ_L enters with adc_req low for one cycle, then raises the low-side request.
          if (r_state == ST_REQ_L && !r_adc_req) begin
            r_adc_req  <= 1'b1;
            r_adc_chan <= adc_chan_enc(r_mot, SIDE_LOW);
            r_tmr      <= '0;
          end else if (adc_ack) begin
            r_adc_req <= 1'b0;
            if (r_state == ST_REQ_H) begin
              r_h     <= adc_data;
              r_state <= ST_REQ_L;
            end else begin
              r_bemf_adc_h <= r_h;
              r_bemf_adc_l <= adc_data;
              r_mot_sel    <= r_mot;
              r_bemf_acc   <= w_acc_rd;
              r_bemf_calib <= w_calib;
              r_upd_valid  <= 1'b1;
              r_state      <= ST_ISSUE;
            end
          end else if (r_tmr == TMR_LAST) begin
            r_adc_req            <= 1'b0;
            r_err_timeout[r_mot] <= 1'b1;
            if (r_mot == LAST_MOT) begin
              r_state <= ST_DRAIN;
            end else begin
              r_mot    <= r_mot + 2'd1;
              r_settle <= SETTLE_LOAD;
              r_state  <= ST_SETTLE;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_mot == LAST_MOT) begin
            r_state <= ST_DRAIN;
          end else begin
            r_mot    <= r_mot + 2'd1;
            r_settle <= SETTLE_LOAD;
            r_state  <= ST_SETTLE;
          end
        end
        ST_DRAIN: begin
          if (r_out == '0) begin
            r_sweep_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_out <= '0;
    else if (w_issue && !wb_valid)
      r_out <= r_out + 3'd1;
    else if (!w_issue && wb_valid)
      r_out <= r_out - 3'd1;
  end

  assign adc_req     = r_adc_req;
  assign adc_chan    = r_adc_chan;
  assign bemf_adc_h  = r_bemf_adc_h;
  assign bemf_adc_l  = r_bemf_adc_l;
  assign mot_sel     = r_mot_sel;
  assign upd_valid   = r_upd_valid;
  assign bemf_acc    = r_bemf_acc;
  assign bemf_calib  = r_bemf_calib;
  assign busy        = (r_state != ST_IDLE);
  assign sweep_done  = r_sweep_done;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_bemf_sequencer.sv
// Bench for bemf_sequencer: ADC responder, 4-cycle write-back stub, sweep-level reference model.
module tb_bemf_sequencer;

  logic        clk;
  logic        rst;
  logic        meas_trigger;
  logic        adc_req;
  logic [2:0]  adc_chan;
  logic        adc_ack;
  logic [9:0]  adc_data;
  logic [79:0] bemf_calib_flat;
  logic [9:0]  bemf_adc_h;
  logic [9:0]  bemf_adc_l;
  logic [1:0]  mot_sel;
  logic        upd_valid;
  logic [19:0] bemf_acc;
  logic [19:0] bemf_calib;
  logic        wb_valid;
  logic [1:0]  wb_mot_sel;
  logic [19:0] wb_bemf;
  logic [3:0]  bemf_clear;
  logic [79:0] bemf_flat;
  logic        busy;
  logic        sweep_done;
  logic [3:0]  err_timeout;
  logic        err_overrun;

  bemf_sequencer #(.SETTLE_CYCLES(16), .ADC_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .meas_trigger(meas_trigger),
    .adc_req(adc_req), .adc_chan(adc_chan), .adc_ack(adc_ack), .adc_data(adc_data),
    .bemf_calib_flat(bemf_calib_flat),
    .bemf_adc_h(bemf_adc_h), .bemf_adc_l(bemf_adc_l), .mot_sel(mot_sel),
    .upd_valid(upd_valid), .bemf_acc(bemf_acc), .bemf_calib(bemf_calib),
    .wb_valid(wb_valid), .wb_mot_sel(wb_mot_sel), .wb_bemf(wb_bemf), .bemf_clear(bemf_clear),
    .bemf_flat(bemf_flat), .busy(busy), .sweep_done(sweep_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Environment knobs
  logic [3:0]  drop_mask = '0;
  int          ack_dly = 3;
  logic [9:0]  h_val [4];
  logic [9:0]  l_val [4];
  logic [19:0] delta = 20'd500;
  bit          clr_en = 0;
  logic [2:0]  chan_log [$];
  int          req_cyc [$];
  int          to_len = 0;

  // ADC responder: acks each request after ack_dly cycles, never acks dropped high sides (late ack after drop).
  initial begin
    logic [2:0] ch;
    int n;
    adc_ack = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_req && !rst) begin
        ch = adc_chan;
        chan_log.push_back(ch);
        req_cyc.push_back(cyc);
        if (ch[0] && drop_mask[ch[2:1]]) begin
          n = 0;
          while (adc_req && n < 1000) begin
            @(negedge clk);
            n++;
          end
          to_len = n;
          adc_ack = 1'b1;
          adc_data = 10'h3FF;
          @(negedge clk);
          adc_ack = 1'b0;
        end else begin
          repeat (ack_dly) @(negedge clk);
          adc_ack = 1'b1;
          adc_data = ch[0] ? h_val[ch[2:1]] : l_val[ch[2:1]];
          @(negedge clk);
          adc_ack = 1'b0;
        end
      end
    end
  end

  // Update-pipeline stub: write-back of bemf_acc+delta, 4 cycles after each beat.
  typedef struct packed { logic v; logic [1:0] mot; logic [19:0] val; } wb_t;
  wb_t p [4];
  int  last_wb_cyc = 0;

  initial begin
    for (int i = 0; i < 4; i++) p[i] = '0;
    wb_valid = 1'b0; wb_mot_sel = '0; wb_bemf = '0; bemf_clear = '0;
    forever begin
      @(negedge clk);
      wb_valid   = p[3].v;
      wb_mot_sel = p[3].mot;
      wb_bemf    = (clr_en && p[3].mot == 2'd1) ? 20'h00123 : p[3].val;
      bemf_clear = (p[3].v && clr_en && p[3].mot == 2'd1) ? 4'b0010 : 4'b0000;
      if (p[3].v) last_wb_cyc = cyc;
      p[3] = p[2]; p[2] = p[1]; p[1] = p[0];
      p[0] = rst ? '0 : {upd_valid, mot_sel, bemf_acc + delta};
    end
  end

  // Beat / sweep_done monitor
  typedef struct packed { logic [1:0] mot; logic [9:0] h; logic [9:0] l; logic [19:0] acc; logic [19:0] cal; } beat_t;
  beat_t beats [$];
  int    sd_count = 0;
  int    sd_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (upd_valid) beats.push_back({mot_sel, bemf_adc_h, bemf_adc_l, bemf_acc, bemf_calib});
    if (sweep_done) begin
      sd_count++;
      sd_cyc = cyc;
    end
  end

  // Reference model: sweep-level bookkeeping of accumulators and sticky flags
  logic [19:0] m_acc [4];
  logic [19:0] m_cal [4];
  logic [3:0]  m_err;
  logic        m_ovr;
  int          trig_cyc = 0;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 4; m++) m_acc[m] = '0;
    m_err = '0;
    m_ovr = 1'b0;
  endtask

  task automatic run_sweep(input logic [3:0] drop, input int dly, input int ovr_mode, input bit clr, input string tag);
    beat_t exp_beats [$];
    logic [2:0] exp_chan [$];
    int sd0, got, pulsed;
    drop_mask = drop; ack_dly = dly; clr_en = clr;
    beats.delete(); chan_log.delete(); req_cyc.delete();
    bemf_calib_flat = {m_cal[3], m_cal[2], m_cal[1], m_cal[0]};
    for (int m = 0; m < 4; m++) begin
      exp_chan.push_back({2'(m), 1'b1});
      if (!drop[m]) begin
        exp_chan.push_back({2'(m), 1'b0});
        exp_beats.push_back({2'(m), h_val[m], l_val[m], m_acc[m], m_cal[m]});
        m_acc[m] = (clr && m == 1) ? 20'd0 : m_acc[m] + delta;
      end
    end
    m_err = m_err | drop;
    if (ovr_mode != 0) m_ovr = 1'b1;
    sd0 = sd_count;
    @(negedge clk);
    meas_trigger = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    meas_trigger = 1'b0;
    got = 0; pulsed = 0;
    for (int i = 0; i < 4000; i++) begin
      if (sweep_done) begin
        got = 1;
        if (ovr_mode == 2) meas_trigger = 1'b1;
        break;
      end
      if (ovr_mode == 1 && pulsed == 0 && chan_log.size() >= 3) begin
        meas_trigger = 1'b1;
        pulsed = 1;
      end else begin
        meas_trigger = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, got, 1);
    @(negedge clk);
    meas_trigger = 1'b0;
    check({tag, "_busy_after_done"}, busy, 1'b0);
    repeat (40) @(negedge clk);
    check({tag, "_sd_pulses"}, sd_count - sd0, 1);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_nreq"}, chan_log.size(), exp_chan.size());
    for (int i = 0; i < exp_chan.size() && i < chan_log.size(); i++)
      check($sformatf("%s_chan%0d", tag, i), chan_log[i], exp_chan[i]);
    check({tag, "_nbeats"}, beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), beats[i], exp_beats[i]);
    if (exp_beats.size() > 0) check({tag, "_sd_after_wb"}, sd_cyc > last_wb_cyc, 1'b1);
    check({tag, "_flat"}, bemf_flat, {m_acc[3], m_acc[2], m_acc[1], m_acc[0]});
    check({tag, "_err_timeout"}, err_timeout, m_err);
    check({tag, "_err_overrun"}, err_overrun, m_ovr);
  endtask

  typedef struct {
    bit         rst_first;
    logic [3:0] drop;
    int         dly;
    int         ovr;
    bit         clr;
    logic [3:0] exp_err;
    bit         exp_ovr;
    int         exp_beats;
  } vec_t;

  initial begin
    vec_t tbl [6];
    string tag;
    int sd0, i;
    tbl[0] = '{1, 4'b0000, 3, 0, 0, 4'b0000, 0, 4};
    tbl[1] = '{1, 4'b0100, 3, 0, 0, 4'b0100, 0, 3};
    tbl[2] = '{1, 4'b0000, 2, 1, 0, 4'b0000, 1, 4};
    tbl[3] = '{0, 4'b0000, 1, 0, 1, 4'b0000, 1, 4};
    tbl[4] = '{1, 4'b1001, 5, 2, 0, 4'b1001, 1, 2};
    tbl[5] = '{1, 4'b1111, 4, 0, 0, 4'b1111, 0, 0};

    meas_trigger = 1'b0;
    bemf_calib_flat = '0;
    for (int m = 0; m < 4; m++) begin
      h_val[m] = 10'd600; l_val[m] = 10'd100; m_cal[m] = '0;
    end
    do_reset();
    check("rst_adc_req", adc_req, 1'b0);
    check("rst_upd_valid", upd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sweep_done", sweep_done, 1'b0);
    check("rst_flat", bemf_flat, '0);
    check("rst_err", {err_timeout, err_overrun}, '0);
    check("rst_beat_outs", {bemf_adc_h, bemf_adc_l, mot_sel, bemf_acc, bemf_calib}, '0);

    for (int r = 0; r < 6; r++) begin
      tag = $sformatf("tbl%0d", r);
      if (tbl[r].rst_first) do_reset();
      if (r > 0)
        for (int m = 0; m < 4; m++) begin
          h_val[m] = 10'(600 + m); l_val[m] = 10'(100 + m); m_cal[m] = 20'h01000 * 20'(m + 1);
        end
      run_sweep(tbl[r].drop, tbl[r].dly, tbl[r].ovr, tbl[r].clr, tag);
      check({tag, "_tbl_err"}, err_timeout, tbl[r].exp_err);
      check({tag, "_tbl_ovr"}, err_overrun, tbl[r].exp_ovr);
      check({tag, "_tbl_beats"}, beats.size(), tbl[r].exp_beats);
      if (r == 0 && req_cyc.size() > 0) check("first_req_latency", req_cyc[0] - trig_cyc, 17);
      if (tbl[r].drop != 0) check({tag, "_timeout_len"}, to_len, 255);
    end

    // Reset during motor 2 low-side request
    do_reset();
    drop_mask = '0; ack_dly = 4; clr_en = 0; delta = 20'h00ABC;
    chan_log.delete();
    sd0 = sd_count;
    @(negedge clk);
    meas_trigger = 1'b1;
    @(negedge clk);
    meas_trigger = 1'b0;
    for (i = 0; i < 2000 && chan_log.size() < 6; i++) @(negedge clk);
    check("midrst_reached_m2_low", chan_log.size() >= 6, 1'b1);
    check("midrst_acc_nonzero", bemf_flat != '0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_adc_req", adc_req, 1'b0);
    check("midrst_upd_valid", upd_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_flat", bemf_flat, '0);
    rst = 1'b0;
    for (int m = 0; m < 4; m++) m_acc[m] = '0;
    m_err = '0; m_ovr = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_sd", sd_count - sd0, 0);
    run_sweep(4'b0000, 2, 0, 0, "postrst");

    // Randomised sweeps against the model
    do_reset();
    for (int s = 0; s < 10; s++) begin
      logic [3:0] drop;
      int om;
      for (int m = 0; m < 4; m++) begin
        h_val[m] = 10'($urandom_range(0, 1023));
        l_val[m] = 10'($urandom_range(0, 1023));
        m_cal[m] = 20'($urandom);
        drop[m] = ($urandom_range(0, 7) == 0);
      end
      delta = 20'($urandom);
      om = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_sweep(drop, int'($urandom_range(1, 6)), om, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", s));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
